// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the controller state enum, the supported opcodes, the ALUOp code
// consumed by alu_control and the ALU operand select encodings.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath (Moore decode of state).
// Latency: R 4, LOAD 5, STORE 4, BRANCH 3, illegal 2 cycles with memory ready.
// Backpressure: mem_ready low holds FETCH/MEM_READ/MEM_WRITE with requests held.
//
// Ports: clk/rst_n (async active-low); opcode, zero, mem_ready in;
// alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
// pc_write_en, pc_source, mem_to_reg, reg_write, illegal_instr out;
// instret = retired-instruction count, state = current state for debug.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write_en,
    output logic             pc_source,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    state_t cur_state;
    state_t nxt_state;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next state and the retire strobe. Retirement is the transition back
    // to FETCH from a completing state; an illegal opcode also returns to
    // FETCH from DECODE but is not a retirement.
    always_comb begin
        nxt_state = cur_state;
        retire    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                if (mem_ready) nxt_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_mem_op(opcode))        nxt_state = S_MEM_ADDR;
                else if (opcode == OP_R)      nxt_state = S_EXECUTE;
                else if (opcode == OP_BRANCH) nxt_state = S_BRANCH;
                else                          nxt_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                nxt_state = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                if (mem_ready) nxt_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    nxt_state = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_EXECUTE: begin
                nxt_state = S_R_WB;
            end
            S_R_WB: begin
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            default: begin
                // Unused encodings fall back to FETCH on the next edge.
                nxt_state = S_FETCH;
            end
        endcase
    end

    // Moore output decode; only pc_write_en/ir_write also look at
    // mem_ready and zero, and they stay purely combinational.
    always_comb begin
        alu_op        = ALUOP_ADD;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write_en   = 1'b0;
        pc_source     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_read    = 1'b1;
                alu_src_a   = SRC_A_PC;
                alu_src_b   = SRC_B_FOUR;
                alu_op      = ALUOP_ADD;
                ir_write    = mem_ready;
                pc_write_en = mem_ready;
            end
            S_DECODE: begin
                // Branch target (oldPC + imm) is parked in ALUOut here.
                alu_src_a     = SRC_A_OLDPC;
                alu_src_b     = SRC_B_IMM;
                alu_op        = ALUOP_ADD;
                illegal_instr = !(is_mem_op(opcode) || opcode == OP_R
                                  || opcode == OP_BRANCH);
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_RS2;
                alu_op      = ALUOP_SUB;
                pc_source   = 1'b1;
                pc_write_en = zero;
            end
            default: begin
            end
        endcase
    end

    // Free-running wrap at 2^CNT_W - 1 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle vector table plus
// hand-written reset-in-flight and counter-wrap sequences.
module tb_multicycle_control;
    import riscv_ctrl_pkg::*;

    localparam logic [6:0] TB_R   = 7'b0110011;
    localparam logic [6:0] TB_LD  = 7'b0000011;
    localparam logic [6:0] TB_ST  = 7'b0100011;
    localparam logic [6:0] TB_BR  = 7'b1100011;
    localparam logic [6:0] TB_BAD = 7'b1111111;

    // Flag vector order: iord, mem_read, mem_write, ir_write, pc_write_en,
    // pc_source, mem_to_reg, reg_write, illegal_instr.
    localparam logic [8:0] IORD = 9'b100000000;
    localparam logic [8:0] MRD  = 9'b010000000;
    localparam logic [8:0] MWR  = 9'b001000000;
    localparam logic [8:0] IRW  = 9'b000100000;
    localparam logic [8:0] PCW  = 9'b000010000;
    localparam logic [8:0] PCS  = 9'b000001000;
    localparam logic [8:0] M2R  = 9'b000000100;
    localparam logic [8:0] RW   = 9'b000000010;
    localparam logic [8:0] ILL  = 9'b000000001;
    localparam logic [8:0] NONE = 9'b000000000;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic [1:0]  alu_op, alu_src_a, alu_src_b;
    logic        iord, mem_read, mem_write, ir_write, pc_write_en;
    logic        pc_source, mem_to_reg, reg_write, illegal_instr;
    logic [31:0] instret;
    logic [3:0]  state;

    logic [1:0]  alu_op4, alu_src_a4, alu_src_b4;
    logic        iord4, mem_read4, mem_write4, ir_write4, pc_write_en4;
    logic        pc_source4, mem_to_reg4, reg_write4, illegal_instr4;
    logic [3:0]  instret4;
    logic [3:0]  state4;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write),
        .pc_write_en(pc_write_en), .pc_source(pc_source),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_instr(illegal_instr), .instret(instret), .state(state)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op4), .alu_src_a(alu_src_a4),
        .alu_src_b(alu_src_b4), .iord(iord4), .mem_read(mem_read4),
        .mem_write(mem_write4), .ir_write(ir_write4),
        .pc_write_en(pc_write_en4), .pc_source(pc_source4),
        .mem_to_reg(mem_to_reg4), .reg_write(reg_write4),
        .illegal_instr(illegal_instr4), .instret(instret4), .state(state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [1:0]  aop;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [8:0]  flags;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic [6:0] op, input logic z,
                                input logic rdy, input state_t st,
                                input logic [1:0] aop, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [8:0] flags,
                                input logic [31:0] ret);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.aop = aop;
        v.sa = sa; v.sb = sb; v.flags = flags; v.ret = ret;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [50:0] actual_vec();
        return {state, alu_op, alu_src_a, alu_src_b,
                iord, mem_read, mem_write, ir_write, pc_write_en,
                pc_source, mem_to_reg, reg_write, illegal_instr, instret};
    endfunction

    initial begin
        vec_t e;

        // R-type, memory always ready (4 cycles).
        tbl.push_back(mk(TB_R,  0, 1, S_FETCH,     2'b00, 2'b00, 2'b01, MRD|IRW|PCW, 0));
        tbl.push_back(mk(TB_R,  0, 0, S_DECODE,    2'b00, 2'b10, 2'b10, NONE,        0));
        tbl.push_back(mk(TB_R,  1, 0, S_EXECUTE,   2'b10, 2'b01, 2'b00, NONE,        0));
        tbl.push_back(mk(TB_R,  0, 1, S_R_WB,      2'b00, 2'b00, 2'b00, RW,          0));
        // LOAD with three wait states in MEM_READ (8 cycles).
        tbl.push_back(mk(TB_LD, 0, 1, S_FETCH,     2'b00, 2'b00, 2'b01, MRD|IRW|PCW, 1));
        tbl.push_back(mk(TB_LD, 0, 1, S_DECODE,    2'b00, 2'b10, 2'b10, NONE,        1));
        tbl.push_back(mk(TB_LD, 0, 0, S_MEM_ADDR,  2'b00, 2'b01, 2'b10, NONE,        1));
        tbl.push_back(mk(TB_LD, 0, 0, S_MEM_READ,  2'b00, 2'b00, 2'b00, IORD|MRD,    1));
        tbl.push_back(mk(TB_LD, 0, 0, S_MEM_READ,  2'b00, 2'b00, 2'b00, IORD|MRD,    1));
        tbl.push_back(mk(TB_LD, 0, 0, S_MEM_READ,  2'b00, 2'b00, 2'b00, IORD|MRD,    1));
        tbl.push_back(mk(TB_LD, 0, 1, S_MEM_READ,  2'b00, 2'b00, 2'b00, IORD|MRD,    1));
        tbl.push_back(mk(TB_LD, 0, 0, S_MEM_WB,    2'b00, 2'b00, 2'b00, RW|M2R,      1));
        // STORE with a fetch wait and a write wait.
        tbl.push_back(mk(TB_ST, 1, 0, S_FETCH,     2'b00, 2'b00, 2'b01, MRD,         2));
        tbl.push_back(mk(TB_ST, 0, 1, S_FETCH,     2'b00, 2'b00, 2'b01, MRD|IRW|PCW, 2));
        tbl.push_back(mk(TB_ST, 0, 1, S_DECODE,    2'b00, 2'b10, 2'b10, NONE,        2));
        tbl.push_back(mk(TB_ST, 0, 1, S_MEM_ADDR,  2'b00, 2'b01, 2'b10, NONE,        2));
        tbl.push_back(mk(TB_ST, 0, 0, S_MEM_WRITE, 2'b00, 2'b00, 2'b00, IORD|MWR,    2));
        tbl.push_back(mk(TB_ST, 0, 1, S_MEM_WRITE, 2'b00, 2'b00, 2'b00, IORD|MWR,    2));
        // Branch taken, then not taken.
        tbl.push_back(mk(TB_BR, 0, 1, S_FETCH,     2'b00, 2'b00, 2'b01, MRD|IRW|PCW, 3));
        tbl.push_back(mk(TB_BR, 1, 1, S_DECODE,    2'b00, 2'b10, 2'b10, NONE,        3));
        tbl.push_back(mk(TB_BR, 1, 0, S_BRANCH,    2'b01, 2'b01, 2'b00, PCS|PCW,     3));
        tbl.push_back(mk(TB_BR, 0, 1, S_FETCH,     2'b00, 2'b00, 2'b01, MRD|IRW|PCW, 4));
        tbl.push_back(mk(TB_BR, 0, 1, S_DECODE,    2'b00, 2'b10, 2'b10, NONE,        4));
        tbl.push_back(mk(TB_BR, 0, 1, S_BRANCH,    2'b01, 2'b01, 2'b00, PCS,         4));
        // Illegal opcode: two cycles, not counted.
        tbl.push_back(mk(TB_BAD, 0, 1, S_FETCH,    2'b00, 2'b00, 2'b01, MRD|IRW|PCW, 5));
        tbl.push_back(mk(TB_BAD, 0, 1, S_DECODE,   2'b00, 2'b10, 2'b10, ILL,         5));
        tbl.push_back(mk(TB_BAD, 0, 0, S_FETCH,    2'b00, 2'b00, 2'b01, MRD,         5));

        // Reset state, checked before any clock edge.
        rst_n = 1'b0; opcode = TB_R; zero = 1'b0; mem_ready = 1'b0;
        #2;
        check("reset_state", 64'(state), 64'(S_FETCH));
        check("reset_instret", 64'(instret), 64'd0);
        check("reset_outputs",
              64'({mem_read, alu_src_b, ir_write, pc_write_en, reg_write, mem_write}),
              64'({1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            opcode = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].rdy;
            sb_q.push_back(tbl[i]);
            #1;
            if (sb_q.size() == 0) begin
                check($sformatf("row%0d_scoreboard_empty", i), 64'd0, 64'd1);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("row%0d", i), 64'(actual_vec()),
                      64'({e.st, e.aop, e.sa, e.sb, e.flags, e.ret}));
                check($sformatf("row%0d_instret4", i), 64'(instret4),
                      64'(e.ret[3:0]));
            end
        end

        // Reset while a LOAD waits in MEM_READ: abandoned, not counted.
        @(negedge clk); opcode = TB_LD; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        check("midrst_pre_state", 64'(state), 64'(S_MEM_READ));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_state", 64'(state), 64'(S_FETCH));
        check("midrst_instret", 64'(instret), 64'd0);
        check("midrst_outputs",
              64'({mem_read, reg_write, iord, ir_write}),
              64'({1'b1, 1'b0, 1'b0, 1'b0}));

        // Sixteen back-to-back branches: 4-bit counter wraps to 0.
        @(negedge clk);
        opcode = TB_BR; zero = 1'b0; mem_ready = 1'b1; rst_n = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        check("wrap_pre32", 64'(instret), 64'd15);
        check("wrap_pre4", 64'(instret4), 64'd15);
        repeat (3) @(posedge clk);
        #1;
        check("wrap_post32", 64'(instret), 64'd16);
        check("wrap_post4", 64'(instret4), 64'd0);
        check("wrap_state", 64'(state4), 64'(S_FETCH));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle RISC-V datapath, directly upstream of `alu_control`. It decodes the instruction opcode held in the IR and sequences each instruction through fetch/decode/execute/memory/writeback states. It drives the 2-bit `alu_op` that `alu_control` consumes, plus all datapath mux selects and write enables. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  7  IR[6:0]; stable from the cycle after the IR write.
- `zero`  in  1  ALU zero flag; combinational, used in BRANCH.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `alu_op`  out  2  to `alu_control`: 00 add, 01 sub, 10 funct-decode.
- `alu_src_a`  out  2  00 PC, 01 reg A (rs1), 10 oldPC.
- `alu_src_b`  out  2  00 reg B (rs2), 01 constant 4, 10 immediate.
- `iord`  out  1  memory address select: 0 PC, 1 ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  load IR (and oldPC).
- `pc_write_en`  out  1  final PC enable: PCWrite | (PCWriteCond & zero).
- `pc_source`  out  1  0 ALU result, 1 ALUOut.
- `mem_to_reg`  out  1  register writeback select: 0 ALUOut, 1 MDR.
- `reg_write`  out  1  register file write enable.
- `illegal_instr`  out  1  asserted in DECODE when the opcode is unsupported.
- `instret`  out  CNT_W  count of retired instructions.
- `state`  out  4  current state, for debug.

## Operation
Supported opcodes are R-type 0110011, LOAD 0000011, STORE 0100011 and BRANCH 1100011. Outputs are a Moore decode of the state; every signal not listed for a state is 0.

- **FETCH**:
  - Drives mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0.
  - ir_write=pc_write_en=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- **DECODE**:
  - Drives alu_src_a=10, alu_src_b=10, alu_op=00, so the branch target is latched in ALUOut.
  - Next state: LOAD/STORE → MEM_ADDR, R → EXECUTE, BRANCH → BRANCH.
  - Any other opcode: illegal_instr=1, next state FETCH, not counted in instret.
- **MEM_ADDR**:
  - Drives alu_src_a=01, alu_src_b=10, alu_op=00.
  - Next state: LOAD → MEM_READ, STORE → MEM_WRITE.
- **MEM_READ**: mem_read=1, iord=1; waits for mem_ready, then goes to MEM_WB.
- **MEM_WB**: reg_write=1, mem_to_reg=1; goes to FETCH and retires.
- **MEM_WRITE**: mem_write=1, iord=1; waits for mem_ready, then goes to FETCH and retires.
- **EXECUTE**: alu_src_a=01, alu_src_b=00, alu_op=10; goes to R_WB.
- **R_WB**: reg_write=1, mem_to_reg=0; goes to FETCH and retires.
- **BRANCH**:
  - Drives alu_src_a=01, alu_src_b=00, alu_op=01, pc_source=1, pc_write_en=zero.
  - Goes to FETCH and retires regardless of zero.
- **instret**:
  - Increments by 1 on each retiring transition.
  - Wraps from 2^CNT_W−1 to 0.
- **Undefined state encodings**: recover to FETCH on the next edge.

## Timing
- **Reset**:
  - rst_n low forces state=FETCH and instret=0 immediately, regardless of clk.
  - Outputs during and after reset are the FETCH decode: mem_read=1, alu_src_b=01, all enables 0 while mem_ready=0.
  - Reset in mid-instruction abandons the instruction; it is not counted.
- **Cycle counts with mem_ready held 1**: R 4 (FETCH, DECODE, EXECUTE, R_WB), LOAD 5, STORE 4, BRANCH 3, illegal 2.
- **Memory wait states**: each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Request signals stay held and the state is unchanged.
- **mem_ready outside memory states**: ignored.
- **pc_write_en and ir_write**: combinational from state, mem_ready and zero. No registered outputs except state and instret.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum (4-bit);
  - opcode constants OP_R, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - the alu_src_a and alu_src_b select constants.
  
  `alu_control` imports the same ALUOp constants.
- Single module; no sub-module. The next-state logic and the output decode are two separate always blocks.

## Test plan
- **Reset in mid-instruction**: assert rst_n=0 while in MEM_READ → state=FETCH asynchronously, instret=0, mem_read=1, reg_write=0.
- **R-type with instant memory**: opcode=0110011, mem_ready=1 → states FETCH, DECODE, EXECUTE, R_WB over 4 cycles; alu_op=10 in EXECUTE; reg_write=1 in cycle 4; instret +1.
- **LOAD with wait states**: opcode=0000011, mem_ready low 3 cycles in MEM_READ → mem_read and iord held for 3 extra cycles; MEM_WB asserts mem_to_reg=1 and reg_write=1; 8 cycles total.
- **Branch taken vs not taken**:
  - opcode=1100011 with zero=1 → pc_write_en=1, pc_source=1, alu_op=01 in BRANCH.
  - With zero=0 → pc_write_en=0.
  - Both cases: 3 cycles, instret +1.
- **Illegal opcode and counter wrap**:
  - opcode=1111111 → illegal_instr=1 in DECODE, back to FETCH, instret unchanged.
  - With CNT_W=4 and 16 retired instructions → instret returns to 0.
